// File: rtl/mm_miss_arbiter.sv
// Shares one main-memory read port between the I-cache and D-cache miss paths.
// Define MM_ARB_PERF_EN to build the fill/wait performance counters.
module mm_miss_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_MISS,
  input  logic [31:0]      I_ADDR,
  input  logic             D_MISS,
  input  logic [31:0]      D_ADDR,
  output logic             MM_REQ,
  output logic [31:0]      MM_ADDR,
  input  logic             MM_ACK,
  input  logic [31:0]      MM_RDATA,
  output logic             I_FILL,
  output logic             D_FILL,
  output logic [31:0]      FILL_DATA,
  output logic [1:0]       GRANT,
  output logic             STALL,
  output logic             ERR,
  output logic [CNT_W-1:0] CNT_I_FILL,
  output logic [CNT_W-1:0] CNT_D_FILL,
  output logic [CNT_W-1:0] CNT_WAIT
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FILL
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q,  last_d;   // 1: D was granted last
  logic [31:0]       addr_q,  addr_d;
  logic [31:0]       data_q,  data_d;
  logic              err_q,   err_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;

  logic              pick_i, pick_d, can_grant;
  logic [31:0]       sel_addr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    wait_d    = wait_q;
    can_grant = 1'b0;

    pick_i   = I_MISS & (~D_MISS | last_q);
    pick_d   = D_MISS & (~I_MISS | ~last_q);
    sel_addr = pick_d ? D_ADDR : I_ADDR;

    unique case (state_q)
      S_IDLE: can_grant = 1'b1;
      S_BUSY: begin
        wait_d = wait_q + WAIT_W'(1);
        if (MM_ACK) begin
          data_d  = MM_RDATA;
          state_d = S_FILL;
        end else if (wait_q == WAIT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        grant_d   = '0;
        state_d   = S_IDLE;
        can_grant = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The FILL cycle arbitrates as IDLE would, so a waiting miss is granted
    // on the edge that leaves FILL and MM_REQ is low for just that one cycle.
    if (can_grant && (pick_i || pick_d)) begin
      state_d = S_BUSY;
      grant_d = pick_d ? 2'b10 : 2'b01;
      last_d  = pick_d;
      addr_d  = sel_addr & 32'hFFFF_FFFC;
      wait_d  = '0;
    end
  end

  assign MM_REQ    = (state_q == S_BUSY);
  assign STALL     = (state_q != S_IDLE);
  assign I_FILL    = (state_q == S_FILL) && (grant_q == 2'b01);
  assign D_FILL    = (state_q == S_FILL) && (grant_q == 2'b10);
  assign MM_ADDR   = addr_q;
  assign FILL_DATA = data_q;
  assign GRANT     = grant_q;
  assign ERR       = err_q;

`ifdef MM_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_i_q, cnt_d_q, cnt_wait_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_i_q    <= '0;
      cnt_d_q    <= '0;
      cnt_wait_q <= '0;
    end else if (state_q == S_BUSY) begin
      cnt_wait_q <= cnt_wait_q + CNT_W'(1);
      if (MM_ACK && grant_q == 2'b01) cnt_i_q <= cnt_i_q + CNT_W'(1);
      if (MM_ACK && grant_q == 2'b10) cnt_d_q <= cnt_d_q + CNT_W'(1);
    end
  end

  assign CNT_I_FILL = cnt_i_q;
  assign CNT_D_FILL = cnt_d_q;
  assign CNT_WAIT   = cnt_wait_q;
`else
  assign CNT_I_FILL = '0;
  assign CNT_D_FILL = '0;
  assign CNT_WAIT   = '0;
`endif

endmodule
